// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle linking the CPU and PDU requesters, dmem_arbiter and DMEM.
// cpu_* / dbg_*: request, write enable, word address, write data, grant, rvalid, rdata.
// dbg_lock/dbg_owned: debug burst lock request and ownership status.
// mem_*: single-port DMEM address, write data, write enable and combinational read data.
// slave is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(parameter int DEPTH = 10);
    logic             cpu_req;
    logic             cpu_we;
    logic [DEPTH-1:0] cpu_addr;
    logic [31:0]      cpu_wdata;
    logic             cpu_gnt;
    logic             cpu_rvalid;
    logic [31:0]      cpu_rdata;
    logic             dbg_req;
    logic             dbg_we;
    logic [DEPTH-1:0] dbg_addr;
    logic [31:0]      dbg_wdata;
    logic             dbg_gnt;
    logic             dbg_rvalid;
    logic [31:0]      dbg_rdata;
    logic             dbg_lock;
    logic             dbg_owned;
    logic [DEPTH-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_owned,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_owned,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port DMEM between the CPU load/store port and the PDU debug port.
// Ports: clk (posedge), rstn (async active-low), bus (dmem_arbiter_if.slave) carrying
// both requester ports, the debug lock/ownership pair and the DMEM drive/read signals.
// One grant per cycle (combinational), read data registered one cycle later.
// Macro DMEM_ARB_RR_EN: round-robin on ties when defined; fixed CPU priority otherwise.
module dmem_arbiter #(parameter int DEPTH = 10) (
    input logic           clk,
    input logic           rstn,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, DBG_OWN} state_t;

    state_t state, state_nxt;
    logic   cpu_gnt, dbg_gnt, dbg_tie;

`ifdef DMEM_ARB_RR_EN
    // High when debug won the most recent grant; reset to CPU-last so debug wins the first tie.
    logic last_dbg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_dbg <= 1'b0;
        else if (cpu_gnt || dbg_gnt)
            last_dbg <= dbg_gnt;
    end

    assign dbg_tie = ~last_dbg;
`else
    assign dbg_tie = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Grants are gated by rstn so nothing is granted while reset is held.
    always_comb begin
        state_nxt = state;
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        if (state == DBG_OWN) begin
            dbg_gnt = rstn && bus.dbg_req;
            if (!bus.dbg_lock)
                state_nxt = IDLE;
        end else begin
            dbg_gnt = rstn && bus.dbg_req && (!bus.cpu_req || dbg_tie);
            cpu_gnt = rstn && bus.cpu_req && !dbg_gnt;
            if (dbg_gnt && bus.dbg_lock)
                state_nxt = DBG_OWN;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.dbg_gnt   = dbg_gnt;
    assign bus.dbg_owned = (state == DBG_OWN);
    assign bus.mem_addr  = dbg_gnt ? bus.dbg_addr : cpu_gnt ? bus.cpu_addr : {DEPTH{1'b0}};
    assign bus.mem_wdata = dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;
    assign bus.mem_we    = (dbg_gnt && bus.dbg_we) || (cpu_gnt && bus.cpu_we);

    // Read data is sampled on the grant edge, so a write acknowledges with the pre-write word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.cpu_rvalid <= 1'b0;
            bus.dbg_rvalid <= 1'b0;
            bus.cpu_rdata  <= 32'h0;
            bus.dbg_rdata  <= 32'h0;
        end else begin
            bus.cpu_rvalid <= cpu_gnt;
            bus.dbg_rvalid <= dbg_gnt;
            if (cpu_gnt)
                bus.cpu_rdata <= bus.mem_rdata;
            if (dbg_gnt)
                bus.dbg_rdata <= bus.mem_rdata;
        end
    end
endmodule
